// File: rtl/dev_input_if.sv
`default_nettype none
// ============================================================================
// Module      : dev_input_if
// Description : CPU read-bus bundle for the input device.
//               en   - read strobe (qualifies read-to-clear side effects)
//               sel  - read-view select
//               dout - 32-bit read data returned by the device
//               irq  - level interrupt, high while any event is pending
//               master = CPU side, slave = device side.
// Revision    : 1.0 - initial release
// ============================================================================
interface dev_input_if;
  logic        en;
  logic [1:0]  sel;
  logic [31:0] dout;
  logic        irq;

  modport master (
    output en,
    output sel,
    input  dout,
    input  irq
  );

  modport slave (
    input  en,
    input  sel,
    output dout,
    output irq
  );
endinterface
`default_nettype wire

// File: rtl/dev_input.sv
`default_nettype none
// ============================================================================
// Module      : dev_input
// Description : CPU-readable input device. Raw switches and push-buttons are
//               synchronised (2 flops) and debounced per bit. Rising edges of
//               the debounced buttons set sticky event flags and bump a
//               saturating press counter. Four 32-bit read views are selected
//               by sel; a strobed read of the event or counter view clears it.
// Ports       : clk     - system clock, rising edge
//               rst     - asynchronous, active-low reset
//               sw_raw  - raw switch pins (async to clk)
//               btn_raw - raw button pins (async, active-high)
//               bus     - read bus (en, sel in; dout, irq out)
// Revision    : 1.0 - initial release
// ============================================================================
module dev_input #(
  parameter int SW_W      = 16,
  parameter int BTN_W     = 4,
  parameter int DB_CYCLES = 4,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SW_W-1:0]  sw_raw,
  input  logic [BTN_W-1:0] btn_raw,
  dev_input_if.slave       bus
);

  // Switches and buttons share one synchroniser/debounce datapath;
  // switches occupy the low bits, buttons the high bits.
  localparam int c_in_w = SW_W + BTN_W;
  localparam int c_db_w = $clog2(DB_CYCLES);

  localparam logic [c_db_w-1:0] c_db_last = c_db_w'(DB_CYCLES - 1);
  localparam logic [c_db_w-1:0] c_db_one  = c_db_w'(1);
  localparam logic [CNT_W-1:0]  c_cnt_max = '1;
  localparam logic [CNT_W-1:0]  c_cnt_one = CNT_W'(1);
  localparam logic [31:0]       c_default_view = 32'h1111_1111;

  localparam logic [1:0] c_sel_sw  = 2'b00;
  localparam logic [1:0] c_sel_evt = 2'b01;
  localparam logic [1:0] c_sel_cnt = 2'b10;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [c_in_w-1:0] sync1_q, sync1_d;
  logic [c_in_w-1:0] sync2_q, sync2_d;
  logic [c_in_w-1:0] stable_q, stable_d;
  logic [c_db_w-1:0] db_cnt_q [c_in_w];
  logic [c_db_w-1:0] db_cnt_d [c_in_w];
  logic [BTN_W-1:0]  btn_prev_q, btn_prev_d;
  logic [BTN_W-1:0]  evt_q, evt_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              irq_q, irq_d;

  logic [c_in_w-1:0] raw_w;
  logic [SW_W-1:0]   sw_stable_w;
  logic [BTN_W-1:0]  btn_stable_w;
  logic [BTN_W-1:0]  rise_w;
  logic              clr_evt_w;
  logic              clr_cnt_w;
  logic [31:0]       dout_w;

  assign raw_w        = {btn_raw, sw_raw};
  assign sw_stable_w  = stable_q[SW_W-1:0];
  assign btn_stable_w = stable_q[c_in_w-1:SW_W];

  // --------------------------------------------------------------------------
  // Synchroniser
  // --------------------------------------------------------------------------
  always_comb begin
    sync1_d = raw_w;
    sync2_d = sync1_q;
  end

  // --------------------------------------------------------------------------
  // Debounce: a bit only follows its synchronised input after DB_CYCLES
  // consecutive mismatching samples; any return to the stable value
  // restarts the count.
  // --------------------------------------------------------------------------
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < c_in_w; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (db_cnt_q[i] == c_db_last) begin
          stable_d[i] = sync2_q[i];
          db_cnt_d[i] = '0;
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + c_db_one;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Event capture and read-to-clear
  // --------------------------------------------------------------------------
  assign rise_w    = btn_stable_w & ~btn_prev_q;
  assign clr_evt_w = bus.en && (bus.sel == c_sel_evt);
  assign clr_cnt_w = bus.en && (bus.sel == c_sel_cnt);

  always_comb begin
    btn_prev_d = btn_stable_w;

    // New edges are OR-ed in after the clear so a set always wins.
    evt_d = (clr_evt_w ? '0 : evt_q) | rise_w;

    cnt_d = cnt_q;
    if (clr_cnt_w) begin
      cnt_d = (|rise_w) ? c_cnt_one : '0;
    end else if ((|rise_w) && (cnt_q != c_cnt_max)) begin
      cnt_d = cnt_q + c_cnt_one;
    end

    // Registered from the next event state so irq tracks evt exactly
    // and never glitches.
    irq_d = |evt_d;
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      stable_q   <= '0;
      for (int i = 0; i < c_in_w; i++) begin
        db_cnt_q[i] <= '0;
      end
      btn_prev_q <= '0;
      evt_q      <= '0;
      cnt_q      <= '0;
      irq_q      <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      stable_q   <= stable_d;
      for (int i = 0; i < c_in_w; i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
      end
      btn_prev_q <= btn_prev_d;
      evt_q      <= evt_d;
      cnt_q      <= cnt_d;
      irq_q      <= irq_d;
    end
  end

  // --------------------------------------------------------------------------
  // Read views
  // --------------------------------------------------------------------------
  always_comb begin
    dout_w = '0;
    case (bus.sel)
      c_sel_sw:  dout_w = 32'(sw_stable_w);
      c_sel_evt: dout_w = 32'(evt_q);
      c_sel_cnt: begin
        dout_w     = 32'(cnt_q);
        dout_w[31] = irq_q;
      end
      default:   dout_w = c_default_view;
    endcase
  end

  assign bus.dout = dout_w;
  assign bus.irq  = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_dev_input.sv
`default_nettype none
// ============================================================================
// Module      : tb_dev_input
// Description : Directed self-checking bench for dev_input (default params).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dev_input;

  logic        clk;
  logic        rst;
  logic [15:0] sw_raw;
  logic [3:0]  btn_raw;
  int          n_cmp;
  int          n_err;

  dev_input_if bus_if ();

  dev_input dut (
    .clk     (clk),
    .rst     (rst),
    .sw_raw  (sw_raw),
    .btn_raw (btn_raw),
    .bus     (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after a rising edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; sw_raw = '0; btn_raw = '0;
    bus_if.en = 1'b0; bus_if.sel = 2'b00;
    tick(2);
    #1;
    n_cmp++;
    if (bus_if.dout !== 32'h0) begin
      $display("FAIL rst_low_sel00 got=%h exp=%h", bus_if.dout, 32'h0); n_err++;
    end
    n_cmp++;
    if (bus_if.irq !== 1'b0) begin
      $display("FAIL rst_low_irq got=%b exp=0", bus_if.irq); n_err++;
    end
    rst = 1'b1;
    tick(2);
    bus_if.sel = 2'b00; #1;
    n_cmp++;
    if (bus_if.dout !== 32'h0) begin
      $display("FAIL reset_sel00 got=%h exp=%h", bus_if.dout, 32'h0); n_err++;
    end
    bus_if.sel = 2'b01; #1;
    n_cmp++;
    if (bus_if.dout !== 32'h0) begin
      $display("FAIL reset_sel01 got=%h exp=%h", bus_if.dout, 32'h0); n_err++;
    end
    bus_if.sel = 2'b10; #1;
    n_cmp++;
    if (bus_if.dout !== 32'h0) begin
      $display("FAIL reset_sel10 got=%h exp=%h", bus_if.dout, 32'h0); n_err++;
    end
    bus_if.sel = 2'b11; #1;
    n_cmp++;
    if (bus_if.dout !== 32'h1111_1111) begin
      $display("FAIL reset_sel11 got=%h exp=%h", bus_if.dout, 32'h1111_1111); n_err++;
    end
    n_cmp++;
    if (bus_if.irq !== 1'b0) begin
      $display("FAIL reset_irq got=%b exp=0", bus_if.irq); n_err++;
    end
  endtask

  task automatic test_switch_latency();
    bus_if.sel = 2'b00;
    sw_raw = 16'hA5A5;
    for (int k = 1; k <= 5; k++) begin
      tick(1);
      n_cmp++;
      if (bus_if.dout !== 32'h0) begin
        $display("FAIL sw_early_clk%0d got=%h exp=%h", k, bus_if.dout, 32'h0); n_err++;
      end
    end
    tick(1);
    n_cmp++;
    if (bus_if.dout !== 32'h0000_A5A5) begin
      $display("FAIL sw_clk6 got=%h exp=%h", bus_if.dout, 32'h0000_A5A5); n_err++;
    end
  endtask

  task automatic test_glitch();
    btn_raw[2] = 1'b1;
    tick(3);
    btn_raw[2] = 1'b0;
    tick(10);
    bus_if.sel = 2'b01; #1;
    n_cmp++;
    if (bus_if.dout !== 32'h0) begin
      $display("FAIL glitch_evt got=%h exp=%h", bus_if.dout, 32'h0); n_err++;
    end
    bus_if.sel = 2'b10; #1;
    n_cmp++;
    if (bus_if.dout !== 32'h0) begin
      $display("FAIL glitch_cnt got=%h exp=%h", bus_if.dout, 32'h0); n_err++;
    end
    n_cmp++;
    if (bus_if.irq !== 1'b0) begin
      $display("FAIL glitch_irq got=%b exp=0", bus_if.irq); n_err++;
    end
  endtask

  task automatic test_press();
    btn_raw[0] = 1'b1; tick(10);
    btn_raw[0] = 1'b0; tick(8);
    btn_raw[0] = 1'b1; tick(8);
    bus_if.sel = 2'b01; #1;
    n_cmp++;
    if (bus_if.dout !== 32'h1) begin
      $display("FAIL press_evt got=%h exp=%h", bus_if.dout, 32'h1); n_err++;
    end
    bus_if.sel = 2'b10; #1;
    n_cmp++;
    if (bus_if.dout !== 32'h8000_0002) begin
      $display("FAIL press_cnt got=%h exp=%h", bus_if.dout, 32'h8000_0002); n_err++;
    end
    n_cmp++;
    if (bus_if.irq !== 1'b1) begin
      $display("FAIL press_irq got=%b exp=1", bus_if.irq); n_err++;
    end
  endtask

  task automatic test_set_wins();
    // btn3 qualifies 6 edges after the pin change; its event lands on edge 7.
    btn_raw[3] = 1'b1;
    tick(6);
    bus_if.sel = 2'b01; bus_if.en = 1'b1; #1;
    n_cmp++;
    if (bus_if.dout !== 32'h1) begin
      $display("FAIL setwin_preclear got=%h exp=%h", bus_if.dout, 32'h1); n_err++;
    end
    tick(1);
    bus_if.en = 1'b0; #1;
    n_cmp++;
    if (bus_if.dout !== 32'h8) begin
      $display("FAIL setwin_evt got=%h exp=%h", bus_if.dout, 32'h8); n_err++;
    end
    n_cmp++;
    if (bus_if.irq !== 1'b1) begin
      $display("FAIL setwin_irq got=%b exp=1", bus_if.irq); n_err++;
    end
    bus_if.en = 1'b1;
    tick(1);
    bus_if.en = 1'b0; #1;
    n_cmp++;
    if (bus_if.dout !== 32'h0) begin
      $display("FAIL clear_evt got=%h exp=%h", bus_if.dout, 32'h0); n_err++;
    end
    n_cmp++;
    if (bus_if.irq !== 1'b0) begin
      $display("FAIL clear_irq got=%b exp=0", bus_if.irq); n_err++;
    end
    btn_raw = '0;
    tick(8);
  endtask

  task automatic test_no_side_effect();
    // cnt so far: 2 (btn0) + 1 (btn3) -> this press makes 4.
    btn_raw[2] = 1'b1; tick(8);
    btn_raw[2] = 1'b0; tick(8);
    bus_if.en = 1'b1; bus_if.sel = 2'b00; tick(1);
    bus_if.sel = 2'b11; tick(1);
    bus_if.en = 1'b0; bus_if.sel = 2'b01; tick(1);
    bus_if.sel = 2'b10; tick(1);
    bus_if.sel = 2'b01; #1;
    n_cmp++;
    if (bus_if.dout !== 32'h4) begin
      $display("FAIL noside_evt got=%h exp=%h", bus_if.dout, 32'h4); n_err++;
    end
    bus_if.sel = 2'b10; #1;
    n_cmp++;
    if (bus_if.dout !== 32'h8000_0004) begin
      $display("FAIL noside_cnt got=%h exp=%h", bus_if.dout, 32'h8000_0004); n_err++;
    end
  endtask

  task automatic test_saturate();
    for (int p = 0; p < 300; p++) begin
      btn_raw[1] = 1'b1; tick(8);
      btn_raw[1] = 1'b0; tick(8);
    end
    bus_if.sel = 2'b01; #1;
    n_cmp++;
    if (bus_if.dout !== 32'h6) begin
      $display("FAIL sat_evt got=%h exp=%h", bus_if.dout, 32'h6); n_err++;
    end
    bus_if.sel = 2'b10; bus_if.en = 1'b1; #1;
    n_cmp++;
    if (bus_if.dout !== 32'h8000_00FF) begin
      $display("FAIL sat_cnt got=%h exp=%h", bus_if.dout, 32'h8000_00FF); n_err++;
    end
    tick(1);
    bus_if.en = 1'b0; #1;
    n_cmp++;
    if (bus_if.dout !== 32'h8000_0000) begin
      $display("FAIL cnt_clear got=%h exp=%h", bus_if.dout, 32'h8000_0000); n_err++;
    end
    // Counter clear coinciding with a new edge leaves cnt at 1.
    btn_raw[0] = 1'b1;
    tick(6);
    bus_if.en = 1'b1;
    tick(1);
    bus_if.en = 1'b0; #1;
    n_cmp++;
    if (bus_if.dout !== 32'h8000_0001) begin
      $display("FAIL cnt_clear_edge got=%h exp=%h", bus_if.dout, 32'h8000_0001); n_err++;
    end
  endtask

  task automatic test_reset_mid_debounce();
    sw_raw = 16'h00FF;
    tick(3);
    rst = 1'b0;
    tick(2);
    bus_if.sel = 2'b00; #1;
    n_cmp++;
    if (bus_if.dout !== 32'h0) begin
      $display("FAIL midrst_sw got=%h exp=%h", bus_if.dout, 32'h0); n_err++;
    end
    n_cmp++;
    if (bus_if.irq !== 1'b0) begin
      $display("FAIL midrst_irq got=%b exp=0", bus_if.irq); n_err++;
    end
    tick(1);
    rst = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick(1);
      n_cmp++;
      if (bus_if.dout !== 32'h0) begin
        $display("FAIL midrst_early_clk%0d got=%h exp=%h", k, bus_if.dout, 32'h0); n_err++;
      end
    end
    tick(1);
    n_cmp++;
    if (bus_if.dout !== 32'h0000_00FF) begin
      $display("FAIL midrst_clk6 got=%h exp=%h", bus_if.dout, 32'h0000_00FF); n_err++;
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_switch_latency();
    test_glitch();
    test_press();
    test_set_wins();
    test_no_side_effect();
    test_saturate();
    test_reset_mid_debounce();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/dev_input.md
Name: dev_input

Overview:
- CPU-readable input device; the read-side counterpart of the CPU-written output device on the same peripheral bus.
- Samples raw board switches and push-buttons, synchronises and debounces them, and latches button press events as sticky, read-to-clear flags.
- The CPU selects one of four 32-bit read views with sel; a read strobe (en) clears the selected event state.
- Drives a level interrupt request while any event is pending.

Parameters:
- SW_W, 16, number of switch inputs.
- BTN_W, 4, number of button inputs.
- DB_CYCLES, 4, consecutive stable sampled cycles required before a debounced bit changes (minimum 2).
- CNT_W, 8, width of the saturating press counter.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  reset, asynchronous and active-low; all state is cleared while low.
- en  in  1  read strobe from CPU; qualifies read-to-clear side effects.
- sel  in  2  read-view select.
- sw_raw  in  SW_W  raw switch pins, asynchronous to clk.
- btn_raw  in  BTN_W  raw button pins, asynchronous, active-high.
- dout  out  32  read data, combinational from sel and registered state.
- irq  out  1  high while any event flag is set.

Behaviour:
- Reset:
  - While rst is low, all synchroniser flops, debounce counters, sw_stable, btn_stable, evt and cnt are 0.
  - Outputs during reset: dout = 0 for sel 00/01/10; irq = 0.
- Synchroniser: every raw bit passes through a 2-flop chain. The output of the second flop is sync[i].
- Debounce, applied per bit to switches and buttons independently:
  - Each bit has a counter of width clog2(DB_CYCLES).
  - If sync[i] == stable[i], the counter is set to 0.
  - Otherwise the counter increments. On the edge where the counter equals DB_CYCLES-1, stable[i] <= sync[i] and the counter is set to 0.
  - Any glitch back to the stable value before that edge restarts the count.
  - Latency from raw pin change to stable change: 2 + DB_CYCLES clocks.
- Event capture:
  - A rising edge of btn_stable[i] (registered previous value 0, current 1) sets evt[i] on the next edge.
  - Falling edges are ignored.
  - cnt increments by 1 in each cycle in which at least one new rising edge is detected, and saturates at 2^CNT_W-1 (no wrap).
- Read views (dout, combinational):
  - sel=00: {zero-extend, sw_stable}.
  - sel=01: {zero-extend, evt}.
  - sel=10: {irq, zeros, cnt}, with cnt in the low CNT_W bits and irq in bit 31.
  - sel=11: constant 32'h11111111, matching the output device's default view.
- Read-to-clear:
  - When en=1 and sel=01 at a clock edge, evt is cleared.
  - When en=1 and sel=10 at a clock edge, cnt is cleared.
  - The CPU samples dout before the edge, so it sees the pre-clear value.
  - sel=00 and sel=11 reads have no side effects.
  - en=0 has no side effects for any sel.
- Simultaneous events:
  - Set wins over clear per bit: a new rising edge in the same cycle as an evt clear leaves that bit at 1; other bits clear.
  - cnt clear in the same cycle as a new edge gives cnt = 1.
- irq = |evt, registered-state derived and glitch-free.
- Reset mid-debounce: the count is discarded. After reset release, a held input must be re-qualified over the full 2 + DB_CYCLES latency.

Test Plan:
- Reset, then hold rst high with all raw inputs 0 -> dout=0 for sel 00/01/10; dout=32'h11111111 for sel=11; irq=0.
- sw_raw = 16'hA5A5 held -> sel=00 dout stays 0 for 5 clocks, then equals 32'h0000A5A5 at clock 6 (DB_CYCLES=4).
- btn_raw[2] pulses high for 3 clocks only (glitch) -> evt stays 0, cnt stays 0, irq stays 0.
- btn_raw[0] pressed and held 10 clocks, released, then pressed again -> sel=01 dout=32'h1; sel=10 dout=32'h80000002; irq=1.
- With evt=4'b0001, assert en with sel=01 while a btn_raw[3] qualified edge lands in the same cycle -> next cycle evt=4'b1000 and irq stays 1. A second en/sel=01 read -> evt=0 and irq=0.
- 300 qualified presses of btn_raw[1] -> cnt saturates at 8'hFF. en with sel=10 -> returns 32'h800000FF, and the next cycle cnt=0. Assert rst low mid-debounce of a held switch -> sw_stable stays 0 until 6 clocks after release of reset.
